// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the dmem_bus. Accepts one request at a time,
// waits LATENCY cycles, commits byte-enabled writes into a word-addressed RAM
// and returns read data / error through a valid-ready response handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE only)
//   req_addr   in   byte address
//   req_we     in   1 = write, 0 = read
//   req_be     in   byte enables for a write
//   req_wdata  in   write data
//   rsp_valid  out  response present (RESP only)
//   rsp_ready  in   requester takes the response
//   rsp_rdata  out  read data; 0 on a write or on an error
//   rsp_err    out  request was misaligned or out of range
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [3:0]            req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int                  IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(DEPTH_WORDS);
  localparam logic [3:0]          CNT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   ev_addr;
  logic                    ev_we;
  logic [3:0]              ev_be;
  logic [DATA_WIDTH-1:0]   ev_wdata;
  logic [IDX_W-1:0]        ev_idx;
  logic                    ev_err;
  logic                    mem_we;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY = 1 the RESP entry coincides with acceptance, so the request
  // is evaluated straight from the inputs instead of the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      ev_addr  = req_addr;
      ev_we    = req_we;
      ev_be    = req_be;
      ev_wdata = req_wdata;
    end else begin
      ev_addr  = addr_q;
      ev_we    = we_q;
      ev_be    = be_q;
      ev_wdata = wdata_q;
    end
    ev_idx = ev_addr[IDX_W+1:2];
    ev_err = (ev_addr[1:0] != 2'b00) || (ev_addr[ADDR_WIDTH-1:2] >= DEPTH_LIM);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          be_d    = req_be;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      if (ev_err) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else if (ev_we) begin
        err_d   = 1'b0;
        rdata_d = '0;
      end else begin
        err_d   = 1'b0;
        rdata_d = mem_q[ev_idx];
      end
    end
  end

  // Gated by reset so a request presented during reset never reaches the RAM.
  assign mem_we = enter_resp && ev_we && !ev_err && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (mem_we && ev_be[k]) begin
        mem_q[ev_idx][8*k +: 8] <= ev_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{1, 2, 5};
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NDUT-1:0]   req_valid = '0;
  logic [NDUT-1:0]   req_ready;
  logic [31:0]       req_addr  [NDUT];
  logic [NDUT-1:0]   req_we = '0;
  logic [3:0]        req_be    [NDUT];
  logic [31:0]       req_wdata [NDUT];
  logic [NDUT-1:0]   rsp_valid;
  logic [NDUT-1:0]   rsp_ready = '1;
  logic [31:0]       rsp_rdata [NDUT];
  logic [NDUT-1:0]   rsp_err;

  logic [31:0]       model [NDUT][DEPTH];
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (LATS[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_we   (req_we[g]),
      .req_be   (req_be[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: misaligned or word index beyond depth is an error; writes merge
  // enabled bytes; reads return the stored word.
  task automatic model_apply(input int d, input logic [31:0] a, input logic w,
                             input logic [3:0] b, input logic [31:0] wd,
                             output logic [31:0] er, output logic ee);
    int unsigned word;
    logic [31:0] cur;
    word = a / 4;
    if ((a % 4) != 0 || word >= DEPTH) begin
      ee = 1'b1;
      er = 32'h0;
    end else if (w) begin
      cur = model[d][word];
      for (int k = 0; k < 4; k++)
        if (b[k]) cur[8*k +: 8] = wd[8*k +: 8];
      model[d][word] = cur;
      ee = 1'b0;
      er = 32'h0;
    end else begin
      ee = 1'b0;
      er = model[d][word];
    end
  endtask

  // Drives one request with rsp_ready high; returns response, latency in cycles
  // (-1 on timeout), the cycle count at acceptance and req_ready before issue.
  task automatic do_txn(input int d, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int acc, output logic rdy);
    rdy          = req_ready[d];
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_we[d]    = w;
    req_be[d]    = b;
    req_wdata[d] = wd;
    @(posedge clk); #1;
    acc          = cyc;
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (rsp_valid[d] !== 1'b1) lat = -1;
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (rsp_ready[d]) begin
      @(posedge clk); #1;
    end
  endtask

  // Full scenario step: run a transaction and compare against the model.
  task automatic txn_check(input int d, input string nm, input logic [31:0] a,
                           input logic w, input logic [3:0] b, input logic [31:0] wd);
    logic [31:0] rd, er;
    logic        ee, e, rdy;
    int          lat, acc;
    model_apply(d, a, w, b, wd, er, ee);
    do_txn(d, a, w, b, wd, rd, e, lat, acc, rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s.req_ready d=%0d got=%b exp=1", nm, d, rdy);
    end
    n_cmp++;
    if (lat !== LATS[d]) begin
      n_err++;
      $display("FAIL %s.latency d=%0d got=%0d exp=%0d", nm, d, lat, LATS[d]);
    end
    n_cmp++;
    if (e !== ee) begin
      n_err++;
      $display("FAIL %s.err d=%0d addr=%h got=%b exp=%b", nm, d, a, e, ee);
    end
    n_cmp++;
    if (rd !== er) begin
      n_err++;
      $display("FAIL %s.rdata d=%0d addr=%h got=%h exp=%h", nm, d, a, rd, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_addr[d] = '0; req_be[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state d=%0d got rdy=%b vld=%b rd=%h err=%b exp 1/0/0/0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, er, wd;
    logic        e, ee, rdy;
    int          lat, acc;
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < DEPTH; w++) begin
        wd = $urandom;
        model_apply(d, 32'(w * 4), 1'b1, 4'hF, wd, er, ee);
        do_txn(d, 32'(w * 4), 1'b1, 4'hF, wd, rd, e, lat, acc, rdy);
      end
  endtask

  task automatic test_roundtrip();
    txn_check(1, "rt_write", 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    txn_check(1, "rt_read", 32'h10, 1'b0, 4'h0, 32'h0);
    n_cmp++;
    if (model[1][4] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rt_model got=%h exp=deadbeef", model[1][4]);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, er;
    logic        e, ee, rdy;
    int          lat, acc;
    txn_check(1, "bl_full", 32'h20, 1'b1, 4'hF, 32'h11223344);
    txn_check(1, "bl_part", 32'h20, 1'b1, 4'h5, 32'hAABBCCDD);
    model_apply(1, 32'h20, 1'b0, 4'h0, 32'h0, er, ee);
    do_txn(1, 32'h20, 1'b0, 4'h0, 32'h0, rd, e, lat, acc, rdy);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL bl_read got=%h exp=11bb33dd", rd);
    end
    txn_check(1, "bl_be0", 32'h20, 1'b1, 4'h0, 32'hFFFFFFFF);
    txn_check(1, "bl_be0_read", 32'h20, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_errors();
    txn_check(1, "err_misaligned", 32'h22, 1'b0, 4'h0, 32'h0);
    txn_check(1, "err_range_wr", 32'h100, 1'b1, 4'hF, 32'hCAFEF00D);
    txn_check(1, "err_after_rd0", 32'h0, 1'b0, 4'h0, 32'h0);
    txn_check(1, "err_last_ok", 32'hFC, 1'b0, 4'h0, 32'h0);
    txn_check(0, "err_mis_wr_l1", 32'h13, 1'b1, 4'hF, 32'h0BADF00D);
    txn_check(0, "err_after_l1", 32'h10, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          r;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 30; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (r == 1) a = (r == 1 && $urandom_range(0, 1) == 1) ? $urandom | 32'h8000_0000
                                                                   : 32'($urandom_range(DEPTH, 300) * 4);
        else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
        txn_check(d, "rand", a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      end
  endtask

  task automatic test_backpressure();
    logic [31:0] er, held;
    logic        ee;
    int          lat;
    model_apply(1, 32'h10, 1'b0, 4'h0, 32'h0, er, ee);
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_addr[1] = 32'h10; req_we[1] = 1'b0; req_be[1] = 4'h0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    lat = 1;
    while (rsp_valid[1] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 2 || rsp_rdata[1] !== er) begin
      n_err++;
      $display("FAIL bp_first lat=%0d rd=%h exp lat=2 rd=%h", lat, rsp_rdata[1], er);
    end
    held = rsp_rdata[1];
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid[1] = 1'b1; req_addr[1] = 32'h20; req_we[1] = 1'b1; req_wdata[1] = 32'h55AA55AA;
        req_be[1] = 4'hF;
      end
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      n_cmp++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== held || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold i=%0d vld=%b rd=%h err=%b rdy=%b exp 1/%h/0/0",
                 i, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], held);
      end
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release vld=%b rd=%h rdy=%b exp 0/0/1", rsp_valid[1], rsp_rdata[1], req_ready[1]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pulse_ignored vld=%b rdy=%b exp 0/1", rsp_valid[1], req_ready[1]);
    end
    txn_check(1, "bp_pulse_nowrite", 32'h20, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_latency_sweep();
    logic [31:0] rd, er;
    logic        e, ee, rdy;
    int          lat, acc, prev;
    for (int d = 0; d < NDUT; d++) begin
      prev = -1;
      for (int i = 0; i < 4; i++) begin
        model_apply(d, 32'(i * 8), 1'b0, 4'h0, 32'h0, er, ee);
        do_txn(d, 32'(i * 8), 1'b0, 4'h0, 32'h0, rd, e, lat, acc, rdy);
        n_cmp++;
        if (lat !== LATS[d] || rd !== er) begin
          n_err++;
          $display("FAIL sweep_latency d=%0d lat=%0d exp=%0d rd=%h exp=%h", d, lat, LATS[d], rd, er);
        end
        if (prev >= 0) begin
          n_cmp++;
          if (acc - prev !== LATS[d] + 1) begin
            n_err++;
            $display("FAIL sweep_spacing d=%0d got=%0d exp=%0d", d, acc - prev, LATS[d] + 1);
          end
        end
        prev = acc;
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    // reset while a write is still waiting
    req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_we[1] = 1'b1;
    req_be[1] = 4'hF; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait vld=%b rdy=%b rd=%h err=%b exp 0/1/0/0",
               rsp_valid[1], req_ready[1], rsp_rdata[1], rsp_err[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_release rdy=%b exp=1", req_ready[1]);
    end
    txn_check(1, "rst_dropped", 32'h30, 1'b0, 4'h0, 32'h0);

    // reset while holding a read response with nonzero data
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_addr[1] = 32'h10; req_we[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    lat = 1;
    while (rsp_valid[1] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (lat !== 2 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_resp lat=%0d vld=%b rd=%h rdy=%b exp 2/0/0/1",
               lat, rsp_valid[1], rsp_rdata[1], req_ready[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    txn_check(1, "rst_resp_mem", 32'h10, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_roundtrip();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_latency_sweep();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the data-memory bus driven by the single-cycle core's `mother_board`. It models the slave end of the `dmem_bus` transaction: it accepts one request at a time, waits a configurable number of cycles, and commits byte-enabled writes into a word-addressed RAM. It returns read data or an error flag through a valid/ready response handshake. It lets the core and its bench run against a memory with wait states instead of a zero-latency array.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of the request.
- `DATA_WIDTH`, 32: data width; fixed at 32, so there are 4 byte lanes.
- `DEPTH_WORDS`, 64: number of 32-bit words in the RAM.
- `LATENCY`, 2: cycles from request acceptance to the first `rsp_valid`; legal range 1–15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_we`  in  1  1 = write, 0 = read.
- `req_be`  in  4  byte enables for a write; ignored on a read.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  read data; 0 on a write or on an error.
- `rsp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values of outputs:
  - `req_ready` = 1.
  - `rsp_valid` = 0.
  - `rsp_rdata` = 0.
  - `rsp_err` = 0.
  - Wait counter = 0.
- RAM contents are not reset.
- `req_ready` is high only in IDLE.
- Accept: in IDLE with `req_valid` = 1, the responder latches addr, we, be and wdata.
  - If `LATENCY` = 1, next state is RESP.
  - Otherwise next state is WAIT with counter = `LATENCY`−2.
- WAIT: if counter = 0, next state is RESP; otherwise decrement the counter. Request inputs are ignored in WAIT.
- On the edge that enters RESP, the responder evaluates the latched request:
  - Error when `addr[1:0]` ≠ 0 or `addr[ADDR_WIDTH-1:2]` ≥ `DEPTH_WORDS`.
    - `rsp_err` = 1 and `rsp_rdata` = 0.
    - No RAM write occurs.
  - Read: `rsp_rdata` = RAM word at that edge; `rsp_err` = 0.
  - Write: RAM lane k is updated with `wdata[8k+7:8k]` for each `be[k]` = 1. Lanes with `be[k]` = 0 keep their contents. `rsp_rdata` = 0.
  - A write with `be` = 0 is legal: no change to the RAM, normal response.
- RESP: `rsp_valid` = 1; `rsp_rdata` and `rsp_err` stay stable until the handshake.
  - When `rsp_ready` = 1, go to IDLE; `rsp_valid`, `rsp_rdata` and `rsp_err` clear to 0 on that edge.
  - While `rsp_ready` = 0, hold RESP indefinitely.
- Only one outstanding request. No request is accepted in the cycle the response handshakes; `req_ready` rises the following cycle.

## Timing
- Request accepted at the edge ending cycle N: `rsp_valid` first high in cycle N+`LATENCY`.
- RAM write visible to a read whose RESP entry is at or after that write's RESP-entry edge.
- Minimum request spacing is `LATENCY`+1 cycles, when `rsp_ready` is held at 1.
- Reset asserted mid-transaction (WAIT or RESP):
  - Outputs go to their reset values immediately (asynchronous).
  - A pending write whose RESP-entry edge has not occurred is dropped.
  - A write already committed stays in RAM.
- Reset deasserted: IDLE with `req_ready` = 1 from the first cycle.

## Test plan
- Write/read round trip, `LATENCY`=2:
  - Write addr 0x10, data 0xDEADBEEF, be = 0xF, accepted in cycle 0 → `rsp_valid` in cycle 2, `rsp_err` = 0.
  - Read addr 0x10 → `rsp_rdata` = 0xDEADBEEF.
- Byte lanes:
  - Write 0x11223344 to 0x20 with be = 0xF.
  - Write 0xAABBCCDD to 0x20 with be = 0x5.
  - Read 0x20 → 0x11BB33DD.
- Errors:
  - Read 0x22 (misaligned) → `rsp_err` = 1, `rsp_rdata` = 0.
  - Write to 0x100 (word 64 ≥ DEPTH) → `rsp_err` = 1; a following read of 0x00 is unchanged.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles after `rsp_valid` rises.
  - `rsp_valid` and data stay stable; `req_ready` stays 0.
  - A `req_valid` pulse in that window is not accepted.
  - After `rsp_ready` = 1, `req_ready` = 1 the next cycle.
- Latency sweep, `LATENCY` ∈ {1, 2, 5}, `rsp_ready` tied to 1:
  - First `rsp_valid` at exactly N+`LATENCY`.
  - Back-to-back requests spaced `LATENCY`+1 cycles.
- Reset mid-operation: assert `reset` in WAIT of a write to 0x30 with data 0x12345678.
  - Outputs go to reset values asynchronously.
  - After release, a read of 0x30 returns the prior contents, not 0x12345678.
